ex_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, directly upstream of the MEM stage.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles and stalls the front of the pipeline while busy.
- Its result is muxed with the ALU output into the EX/MEM register, so it reaches the MEM stage as the ALU result.

---
 rtl/ex_muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit for the EX stage; stalls the
//            front of the pipeline while busy and pulses DONE_EX with a result.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START_EX,
    input  logic [2:0]       FUNCT3_EX,
    input  logic [WIDTH-1:0] OP_A_EX,
    input  logic [WIDTH-1:0] OP_B_EX,
    input  logic [4:0]       RD_EX,
    input  logic             FLUSH_EX,
    output logic             STALL_EX,
    output logic             DONE_EX,
    output logic [WIDTH-1:0] RESULT_EX,
    output logic [4:0]       RD_EX_out
);

    localparam int          c_CNT_W   = $clog2(WIDTH);
    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_CALC = 2'd1;
    localparam logic [1:0]  c_ST_DONE = 2'd2;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_f3;
    logic [4:0]         r_rd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opa;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_res_hold;
    logic [4:0]         r_rd_hold;

    // Operand decode at issue
    logic             w_is_div;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_special;

    assign w_is_div   = FUNCT3_EX[2];
    assign w_sa       = OP_A_EX[WIDTH-1] &
                        ((FUNCT3_EX == 3'b001) || (FUNCT3_EX == 3'b010) ||
                         (FUNCT3_EX == 3'b100) || (FUNCT3_EX == 3'b110));
    assign w_sb       = OP_B_EX[WIDTH-1] &
                        ((FUNCT3_EX == 3'b001) || (FUNCT3_EX == 3'b100) ||
                         (FUNCT3_EX == 3'b110));
    assign w_abs_a    = w_sa ? (~OP_A_EX + WIDTH'(1)) : OP_A_EX;
    assign w_abs_b    = w_sb ? (~OP_B_EX + WIDTH'(1)) : OP_B_EX;
    assign w_div_zero = w_is_div && (OP_B_EX == '0);
    assign w_div_ovf  = w_is_div && !FUNCT3_EX[0] &&
                        (OP_A_EX == c_MIN_NEG) && (OP_B_EX == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    // Radix-2 step datapath
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ok;

    assign w_mul_sum   = {1'b0, r_hi} + ({(WIDTH+1){r_lo[0]}} & {1'b0, r_opa});
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opa};
    assign w_div_ok    = ~w_div_diff[WIDTH];

    // Final sign correction; high word of -{hi,lo} is ~hi plus carry out of ~lo+1
    logic [WIDTH-1:0] w_mulh;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_final;

    assign w_mulh = r_neg_q ? (~r_hi + WIDTH'(r_lo == '0)) : r_hi;
    assign w_quo  = r_neg_q ? (~r_lo + WIDTH'(1)) : r_lo;
    assign w_rem  = r_neg_r ? (~r_hi + WIDTH'(1)) : r_hi;

    always_comb begin
        w_final = r_lo;
        case (r_f3)
            3'b000:                 w_final = r_lo;
            3'b001, 3'b010, 3'b011: w_final = w_mulh;
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides start and completion
    always_comb begin
        w_state_nxt = r_state;
        if (FLUSH_EX) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (START_EX) begin
                        w_state_nxt = w_special ? c_ST_DONE : c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
                c_ST_DONE: w_state_nxt = c_ST_IDLE;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        STALL_EX  = ((r_state == c_ST_IDLE) && START_EX) || (r_state == c_ST_CALC);
        DONE_EX   = (r_state == c_ST_DONE) && !FLUSH_EX;
        RESULT_EX = DONE_EX ? w_final : r_res_hold;
        RD_EX_out = DONE_EX ? r_rd : r_rd_hold;
    end

    // Operand capture, iteration and result hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_f3       <= '0;
            r_rd       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opa      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_res_hold <= '0;
            r_rd_hold  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (START_EX && !FLUSH_EX) begin
                        r_f3  <= FUNCT3_EX;
                        r_rd  <= RD_EX;
                        r_cnt <= '0;
                        r_hi  <= '0;
                        if (w_div_zero) begin
                            r_lo    <= '1;
                            r_hi    <= OP_A_EX;
                            r_opa   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_div_ovf) begin
                            r_lo    <= c_MIN_NEG;
                            r_opa   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_is_div) begin
                            r_lo    <= w_abs_a;
                            r_opa   <= w_abs_b;
                            r_neg_q <= w_sa ^ w_sb;
                            r_neg_r <= w_sa;
                        end else begin
                            r_lo    <= w_abs_b;
                            r_opa   <= w_abs_a;
                            r_neg_q <= w_sa ^ w_sb;
                            r_neg_r <= 1'b0;
                        end
                    end
                end
                c_ST_CALC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_f3[2]) begin
                        r_hi <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
                    end else begin
                        r_hi <= w_mul_sum[WIDTH:1];
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end
                end
                c_ST_DONE: begin
                    if (!FLUSH_EX) begin
                        r_res_hold <= w_final;
                        r_rd_hold  <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Brief    : Scoreboard bench for ex_muldiv_unit with directed RV32M vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        START_EX = 1'b0;
    logic [2:0]  FUNCT3_EX = '0;
    logic [31:0] OP_A_EX = '0;
    logic [31:0] OP_B_EX = '0;
    logic [4:0]  RD_EX = '0;
    logic        FLUSH_EX = 1'b0;
    logic        STALL_EX;
    logic        DONE_EX;
    logic [31:0] RESULT_EX;
    logic [4:0]  RD_EX_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] sb_q[$];

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .START_EX  (START_EX),
        .FUNCT3_EX (FUNCT3_EX),
        .OP_A_EX   (OP_A_EX),
        .OP_B_EX   (OP_B_EX),
        .RD_EX     (RD_EX),
        .FLUSH_EX  (FLUSH_EX),
        .STALL_EX  (STALL_EX),
        .DONE_EX   (DONE_EX),
        .RESULT_EX (RESULT_EX),
        .RD_EX_out (RD_EX_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (DONE_EX === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: result 0x%08h rd %0d with no pending op", RESULT_EX, RD_EX_out);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                check("sb_result", RESULT_EX, e[31:0]);
                check("sb_rd", {27'd0, RD_EX_out}, {27'd0, e[36:32]});
            end
        end
    end

    // Issue one op at a negedge, measure latency/stall, optionally inject a START mid-CALC
    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_lat, input bit inject);
        int lat;
        int stalls;
        bit seen;
        lat = 0; stalls = 0; seen = 0;
        sb_q.push_back({rd, exp});
        FUNCT3_EX = f3; OP_A_EX = a; OP_B_EX = b; RD_EX = rd; START_EX = 1'b1;
        #1;
        if (STALL_EX) stalls++;
        @(posedge clk);
        #1;
        START_EX = 1'b0; OP_A_EX = '0; OP_B_EX = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (inject && lat == 5) begin
                START_EX = 1'b1; FUNCT3_EX = 3'b000; OP_A_EX = 32'h1234_5678;
                OP_B_EX = 32'h0000_0003; RD_EX = 5'd31;
            end else if (inject && lat == 6) begin
                START_EX = 1'b0;
            end
            if (DONE_EX) seen = 1;
            else if (STALL_EX) stalls++;
        end
        START_EX = 1'b0;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no DONE_EX within 40 cycles, expected latency %0d", name, exp_lat);
        end else begin
            check({name, "_latency"}, lat, exp_lat);
            check({name, "_stall_cycles"}, stalls, exp_lat);
        end
        @(negedge clk);
        check({name, "_hold"}, RESULT_EX, exp);
        check({name, "_stall_idle"}, {31'd0, STALL_EX}, 32'd0);
    endtask

    initial begin
        #1;
        check("reset_stall", {31'd0, STALL_EX}, 32'd0);
        check("reset_done", {31'd0, DONE_EX}, 32'd0);
        check("reset_result", RESULT_EX, 32'd0);
        check("reset_rd", {27'd0, RD_EX_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op("mul_7_m3",   3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33, 0);
        do_op("mul_shift",  3'b000, 32'h1234_5678, 32'h0000_0010, 5'd2,  32'h2345_6780, 33, 0);
        do_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 33, 0);
        do_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33, 0);
        do_op("mulhu_m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33, 0);
        do_op("mulhu_2p33", 3'b011, 32'h8000_0000, 32'h0000_0004, 5'd6,  32'h0000_0002, 33, 0);
        do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33, 0);
        do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33, 0);
        do_op("div_7_m2",   3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, 33, 0);
        do_op("rem_7_m2",   3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd10, 32'h0000_0001, 33, 0);
        do_op("divu_100_7", 3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        33, 0);
        do_op("remu_100_7", 3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         33, 0);
        do_op("div_by0",    3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1,  0);
        do_op("rem_by0",    3'b110, 32'd5,         32'd0,         5'd14, 32'd5,         1,  0);
        do_op("divu_by0",   3'b101, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1,  0);
        do_op("remu_by0",   3'b111, 32'd5,         32'd0,         5'd16, 32'd5,         1,  0);
        do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1,  0);
        do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1,  0);
        do_op("divu_inj",   3'b101, 32'd1000,      32'd10,        5'd19, 32'd100,       33, 1);

        // Flush at counter 10: no DONE, then an immediate new op completes
        FUNCT3_EX = 3'b101; OP_A_EX = 32'd1000; OP_B_EX = 32'd3; RD_EX = 5'd20; START_EX = 1'b1;
        @(posedge clk);
        #1;
        START_EX = 1'b0;
        for (int i = 0; i < 11; i++) @(negedge clk);
        FLUSH_EX = 1'b1;
        @(negedge clk);
        FLUSH_EX = 1'b0;
        check("flush_idle_stall", {31'd0, STALL_EX}, 32'd0);
        check("flush_no_done", {31'd0, DONE_EX}, 32'd0);
        do_op("after_flush", 3'b111, 32'd100, 32'd7, 5'd21, 32'd2, 33, 0);

        // Asynchronous reset between edges mid-CALC
        FUNCT3_EX = 3'b000; OP_A_EX = 32'd9; OP_B_EX = 32'd9; RD_EX = 5'd22; START_EX = 1'b1;
        @(posedge clk);
        #1;
        START_EX = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_stall", {31'd0, STALL_EX}, 32'd0);
        check("areset_done", {31'd0, DONE_EX}, 32'd0);
        check("areset_result", RESULT_EX, 32'd0);
        check("areset_rd", {27'd0, RD_EX_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) @(negedge clk);
        check("areset_idle_stall", {31'd0, STALL_EX}, 32'd0);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
